// File: rtl/mux_nway_stream.sv
// mux_nway_stream
//   Selects one of WAYS input channels (WIDTH bits each) onto a single
//   registered output using valid/ready handshakes. The channel is picked
//   either by the sel port (fixed mode) or by a round-robin arbiter that
//   rotates priority past the most recently served channel.
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   reset      synchronous, active-high reset
//   mode       0 = fixed select via sel, 1 = round-robin
//   sel        channel index used in fixed mode (sel >= WAYS means no request)
//   in_data    channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit high)
//   out_data   registered data of the accepted beat
//   out_chan   index of the channel that produced out_data
//   out_valid  output register holds a beat
//   out_ready  consumer accepts the held beat
//
// Parameters
//   WIDTH  data bits per channel
//   WAYS   number of input channels (2..16)
//   SEL_W  channel-index width, must equal clog2(WAYS)

module mux_nway_stream #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8,
  parameter int SEL_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [WAYS*WIDTH-1:0]   in_data,
  input  logic [WAYS-1:0]         in_valid,
  output logic [WAYS-1:0]         in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_chan,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Output stage occupancy
  localparam logic STATE_EMPTY = 1'b0;
  localparam logic STATE_FULL  = 1'b1;

  localparam logic [SEL_W:0]   WAYS_EXT  = (SEL_W+1)'(WAYS);
  localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(WAYS - 1);

  logic             state;
  logic [SEL_W-1:0] rr_ptr;

  logic             load_en;
  logic             fixed_ok;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_ok;
  logic [SEL_W:0]   rr_cand;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  assign out_valid = (state == STATE_FULL);

  // The output register can take a new beat when it is empty or when its
  // current beat is being drained on this same edge.
  assign load_en = (state == STATE_EMPTY) || out_ready;

  // Fixed mode: only the selected channel can be served. Matching sel
  // against each real channel index makes an out-of-range sel (possible when
  // WAYS is not a power of two) fall through as "no request".
  always_comb begin
    fixed_ok = 1'b0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (sel == SEL_W'(i)) begin
        fixed_ok = in_valid[i];
      end
    end
  end

  // Round-robin: candidates are rr_ptr+1, rr_ptr+2, ... modulo WAYS.
  // Offsets are visited from furthest to nearest so the nearest requesting
  // channel is the last assignment and therefore wins. rr_ptr is always a
  // valid index, so a single conditional subtraction gives the modulo.
  always_comb begin
    rr_grant = '0;
    rr_ok    = 1'b0;
    rr_cand  = '0;
    for (int unsigned k = WAYS; k > 0; k--) begin
      rr_cand = {1'b0, rr_ptr} + (SEL_W+1)'(k);
      if (rr_cand >= WAYS_EXT) begin
        rr_cand = rr_cand - WAYS_EXT;
      end
      if (in_valid[rr_cand[SEL_W-1:0]]) begin
        rr_grant = rr_cand[SEL_W-1:0];
        rr_ok    = 1'b1;
      end
    end
  end

  always_comb begin
    if (mode) begin
      grant    = rr_grant;
      grant_ok = rr_ok;
    end else begin
      grant    = sel;
      grant_ok = fixed_ok;
    end
  end

  // grant_ok already implies in_valid[grant], so a transfer happens whenever
  // the output stage can load and the granted channel is requesting.
  assign xfer = load_en && grant_ok;

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      in_ready[i] = !reset && xfer && (grant == SEL_W'(i));
    end
  end

  // Granted channel's data; a decoded mux keeps the slice in range even
  // when grant is an unused index.
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= STATE_EMPTY;
      out_data <= '0;
      out_chan <= '0;
      rr_ptr   <= LAST_CHAN;
    end else if (load_en) begin
      if (xfer) begin
        state    <= STATE_FULL;
        out_data <= grant_data;
        out_chan <= grant;
        // Priority rotates only on round-robin transfers; fixed-mode traffic
        // leaves the arbiter position untouched across mode switches.
        if (mode) begin
          rr_ptr <= grant;
        end
      end else begin
        state <= STATE_EMPTY;
      end
    end
  end

endmodule
